id_ex_stage: RTL and testbench

// ID/EX pipeline register with load-use hazard detection and EX-operand forwarding.

---
 rtl/mips_pipe_pkg.sv | 43 ++++
 rtl/fwd_unit.sv | 41 ++++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline slice: control-bundle layout,
// register-number constants and the operand-forwarding source select.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Control bundle, MSB first: RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,Jal,ALUOp[2:0]
    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWR    = 9;
    localparam int CTRL_MEMRD    = 8;
    localparam int CTRL_MEMWR    = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_JAL      = 3;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_ALUOP_W  = 3;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never bypassed.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  exmem_regwr,
        input logic [REG_ADDR_W-1:0] exmem_rd,
        input logic                  memwb_regwr,
        input logic [REG_ADDR_W-1:0] memwb_rd
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (exmem_regwr && (exmem_rd != REG_ZERO) && (exmem_rd == src))
            sel = FWD_EXMEM;
        else if (memwb_regwr && (memwb_rd != REG_ZERO) && (memwb_rd == src))
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-operand forwarding: picks EX/MEM, MEM/WB or the registered read data
// for both ALU operands (index 0 = rs/A, index 1 = rt/B).
module fwd_unit #(
    parameter int DW = 32
) (
    input  logic [4:0]    ex_rs,
    input  logic [4:0]    ex_rt,
    input  logic [DW-1:0] ex_rdata1,
    input  logic [DW-1:0] ex_rdata2,
    input  logic          exmem_regwr,
    input  logic [4:0]    exmem_rd,
    input  logic [DW-1:0] exmem_alu,
    input  logic          memwb_regwr,
    input  logic [4:0]    memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] ex_opA,
    output logic [DW-1:0] ex_opB
);
    import mips_pipe_pkg::*;

    logic [1:0][4:0]    src;
    logic [1:0][DW-1:0] rdata;
    logic [1:0][DW-1:0] op;

    assign src   = {ex_rt, ex_rs};
    assign rdata = {ex_rdata2, ex_rdata1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            fwd_sel_e sel;
            assign sel    = fwd_select(src[gi], exmem_regwr, exmem_rd, memwb_regwr, memwb_rd);
            assign op[gi] = (sel == FWD_EXMEM) ? exmem_alu  :
                            (sel == FWD_MEMWB) ? memwb_data : rdata[gi];
        end
    endgenerate

    assign ex_opA = op[0];
    assign ex_opB = op[1];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion, a saturating
// bubble counter and forwarded EX operands.
module id_ex_stage #(
    parameter int DW     = 32,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DW-1:0]     id_rdata1,
    input  logic [DW-1:0]     id_rdata2,
    input  logic [DW-1:0]     id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              hold,
    input  logic              exmem_regwr,
    input  logic [4:0]        exmem_rd,
    input  logic [DW-1:0]     exmem_alu,
    input  logic              memwb_regwr,
    input  logic [4:0]        memwb_rd,
    input  logic [DW-1:0]     memwb_data,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DW-1:0]     ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DW-1:0]     ex_opA,
    output logic [DW-1:0]     ex_opB,
    output logic [CNT_W-1:0]  stall_cnt
);
    import mips_pipe_pkg::*;

    logic              valid_reg,  valid_next;
    logic [4:0]        rs_reg,     rs_next;
    logic [4:0]        rt_reg,     rt_next;
    logic [4:0]        rd_reg,     rd_next;
    logic [DW-1:0]     imm_reg,    imm_next;
    logic [DW-1:0]     rdata1_reg, rdata1_next;
    logic [DW-1:0]     rdata2_reg, rdata2_next;
    logic [CTRL_W-1:0] ctrl_reg,   ctrl_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic              load_use;

    // A load in EX whose target is read by the instruction in ID.
    assign load_use = valid_reg && ctrl_reg[CTRL_MEMRD] && (rt_reg != REG_ZERO) && id_valid &&
                      ((rt_reg == id_rs) || (id_uses_rt && (rt_reg == id_rt)));

    assign stall_o = Resetn && load_use && !flush;

    always_comb begin
        valid_next  = valid_reg;
        rs_next     = rs_reg;
        rt_next     = rt_reg;
        rd_next     = rd_reg;
        imm_next    = imm_reg;
        rdata1_next = rdata1_reg;
        rdata2_next = rdata2_reg;
        ctrl_next   = ctrl_reg;
        cnt_next    = cnt_reg;
        if (!Resetn) begin
            valid_next  = 1'b0;
            rs_next     = '0;
            rt_next     = '0;
            rd_next     = '0;
            imm_next    = '0;
            rdata1_next = '0;
            rdata2_next = '0;
            ctrl_next   = '0;
            cnt_next    = '0;
        end else if (flush) begin
            valid_next = 1'b0;
            ctrl_next  = '0;
        end else if (hold) begin
            // everything, including the bubble counter, stays put
        end else if (load_use) begin
            valid_next = 1'b0;
            ctrl_next  = '0;
            cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
        end else begin
            valid_next  = id_valid;
            rs_next     = id_rs;
            rt_next     = id_rt;
            rd_next     = id_rd;
            imm_next    = id_imm;
            rdata1_next = id_rdata1;
            rdata2_next = id_rdata2;
            ctrl_next   = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge Clock) begin
        valid_reg  <= valid_next;
        rs_reg     <= rs_next;
        rt_reg     <= rt_next;
        rd_reg     <= rd_next;
        imm_reg    <= imm_next;
        rdata1_reg <= rdata1_next;
        rdata2_reg <= rdata2_next;
        ctrl_reg   <= ctrl_next;
        cnt_reg    <= cnt_next;
    end

    fwd_unit #(.DW(DW)) u_fwd (
        .ex_rs       (rs_reg),
        .ex_rt       (rt_reg),
        .ex_rdata1   (rdata1_reg),
        .ex_rdata2   (rdata2_reg),
        .exmem_regwr (exmem_regwr),
        .exmem_rd    (exmem_rd),
        .exmem_alu   (exmem_alu),
        .memwb_regwr (memwb_regwr),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .ex_opA      (ex_opA),
        .ex_opB      (ex_opB)
    );

    assign ex_valid  = valid_reg;
    assign ex_rs     = rs_reg;
    assign ex_rt     = rt_reg;
    assign ex_rd     = rd_reg;
    assign ex_imm    = imm_reg;
    assign ex_ctrl   = ctrl_reg;
    assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model
// of the ID/EX slot, load-use rule and forwarding priority.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    localparam int DW    = 32;
    localparam int CW    = CTRL_W;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic          Clock, Resetn;
    logic          id_valid, id_uses_rt, flush, hold;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          exmem_regwr, memwb_regwr;
    logic [4:0]    exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_alu, memwb_data;
    logic          stall_o, ex_valid;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_imm, ex_opA, ex_opB;
    logic [CW-1:0] ex_ctrl;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage #(.DW(DW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
        .exmem_regwr(exmem_regwr), .exmem_rd(exmem_rd), .exmem_alu(exmem_alu),
        .memwb_regwr(memwb_regwr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .stall_cnt(stall_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model of the ID/EX slot contents
    logic          m_valid;
    logic [4:0]    m_rs, m_rt, m_rd;
    logic [DW-1:0] m_imm, m_rd1, m_rd2;
    logic [CW-1:0] m_ctrl;
    int            m_cnt;

    logic [CW-1:0] lw_ctrl, add_ctrl;

    function automatic logic [DW-1:0] m_fwd(input logic [4:0] r, input logic [DW-1:0] regval);
        if (exmem_regwr && exmem_rd != 0 && exmem_rd == r) return exmem_alu;
        if (memwb_regwr && memwb_rd != 0 && memwb_rd == r) return memwb_data;
        return regval;
    endfunction

    function automatic bit m_lu();
        bit hit;
        hit = (m_rt == id_rs) || (id_uses_rt && m_rt == id_rt);
        return m_valid && m_ctrl[CTRL_MEMRD] && m_rt != 0 && id_valid && hit;
    endfunction

    task automatic check_all();
        check_eq("stall_o",   64'(stall_o),   64'(Resetn && m_lu() && !flush));
        check_eq("ex_valid",  64'(ex_valid),  64'(m_valid));
        check_eq("ex_ctrl",   64'(ex_ctrl),   64'(m_ctrl));
        check_eq("ex_rs",     64'(ex_rs),     64'(m_rs));
        check_eq("ex_rt",     64'(ex_rt),     64'(m_rt));
        check_eq("ex_rd",     64'(ex_rd),     64'(m_rd));
        check_eq("ex_imm",    64'(ex_imm),    64'(m_imm));
        check_eq("ex_opA",    64'(ex_opA),    64'(m_fwd(m_rs, m_rd1)));
        check_eq("ex_opB",    64'(ex_opB),    64'(m_fwd(m_rt, m_rd2)));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic model_clock();
        bit lu;
        lu = m_lu();
        if (!Resetn) begin
            m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
            m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_ctrl = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_ctrl = 0;
        end else if (hold) begin
            m_cnt = m_cnt;
        end else if (lu) begin
            m_valid = 0; m_ctrl = 0;
            if (m_cnt < MAXC) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_imm = id_imm; m_rd1 = id_rdata1; m_rd2 = id_rdata2;
            m_ctrl = id_valid ? id_ctrl : '0;
        end
    endtask

    // Check the current cycle at the falling edge, then advance one clock.
    task automatic step();
        @(negedge Clock);
        check_all();
        $display("cycle t=%0t rst_n=%0b v=%0b stall=%0b cnt=%0d opA=%0h opB=%0h",
                 $time, Resetn, ex_valid, stall_o, stall_cnt, ex_opA, ex_opB);
        model_clock();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urt, input logic [CW-1:0] c,
                          input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_ctrl = c; id_rdata1 = r1; id_rdata2 = r2; id_imm = DW'($urandom);
    endtask

    task automatic rand_id();
        set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), CW'($urandom),
               DW'($urandom), DW'($urandom));
        if ($urandom_range(0, 1) == 1) id_ctrl[CTRL_MEMRD] = 1'b1;
    endtask

    task automatic rand_fwd();
        exmem_regwr = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_alu = DW'($urandom);
        memwb_regwr = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_data = DW'($urandom);
    endtask

    task automatic quiet_fwd();
        exmem_regwr = 0; exmem_rd = 0; exmem_alu = 0;
        memwb_regwr = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    logic [CW-1:0]    sv_ctrl;
    logic [DW-1:0]    sv_opA, sv_imm;
    logic [4:0]       sv_rs;
    logic             sv_valid;
    logic [CNT_W-1:0] sv_cnt;

    initial begin
        lw_ctrl  = '0;
        lw_ctrl[CTRL_REGWR] = 1; lw_ctrl[CTRL_MEMRD] = 1; lw_ctrl[CTRL_MEMTOREG] = 1; lw_ctrl[CTRL_ALUSRC] = 1;
        add_ctrl = '0;
        add_ctrl[CTRL_REGWR] = 1; add_ctrl[CTRL_REGDST] = 1; add_ctrl[CTRL_ALUOP_LSB+1] = 1;
        m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_ctrl = 0; m_cnt = 0;

        // Reset with random inputs for two cycles
        Resetn = 0; flush = 1'($urandom); hold = 1'($urandom); rand_id(); rand_fwd();
        @(posedge Clock); #1;
        rand_id(); rand_fwd(); flush = 1'($urandom); hold = 1'($urandom);
        step();
        check_eq("rst_valid", 64'(ex_valid), 64'd0);
        check_eq("rst_ctrl",  64'(ex_ctrl),  64'd0);
        check_eq("rst_cnt",   64'(stall_cnt), 64'd0);
        check_eq("rst_imm",   64'(ex_imm),   64'd0);

        // Load-use: lw $8 then add using $8
        Resetn = 1; flush = 0; hold = 0; quiet_fwd();
        set_id(1, 5'd3, 5'd8, 5'd8, 0, lw_ctrl, 32'h0, 32'h0);
        step();
        set_id(1, 5'd8, 5'd9, 5'd10, 1, add_ctrl, 32'h11, 32'h22);
        #1 check_eq("lu_stall", 64'(stall_o), 64'd1);
        step();
        check_eq("lu_bub_valid", 64'(ex_valid), 64'd0);
        check_eq("lu_bub_ctrl",  64'(ex_ctrl),  64'd0);
        check_eq("lu_cnt1",      64'(stall_cnt), 64'd1);
        step();
        check_eq("lu_cap_valid", 64'(ex_valid), 64'd1);
        check_eq("lu_cap_ctrl",  64'(ex_ctrl),  64'(add_ctrl));

        // Forwarding priority on rs=5
        set_id(1, 5'd5, 5'd6, 5'd11, 1, add_ctrl, 32'h1111, 32'h2222);
        step();
        id_valid = 0;
        exmem_regwr = 1; exmem_rd = 5; exmem_alu = 32'hAAAA;
        memwb_regwr = 1; memwb_rd = 5; memwb_data = 32'hBBBB;
        #1 check_eq("fwd_exmem", 64'(ex_opA), 64'h AAAA);
        check_eq("fwd_opB_reg", 64'(ex_opB), 64'h2222);
        exmem_regwr = 0;
        #1 check_eq("fwd_memwb", 64'(ex_opA), 64'hBBBB);
        step();

        // Register 0 is never forwarded; lw $0 never stalls
        set_id(1, 5'd0, 5'd0, 5'd12, 1, add_ctrl, 32'h1234, 32'h5678);
        step();
        exmem_regwr = 1; exmem_rd = 0; memwb_regwr = 1; memwb_rd = 0;
        #1 check_eq("fwd_r0_A", 64'(ex_opA), 64'h1234);
        check_eq("fwd_r0_B", 64'(ex_opB), 64'h5678);
        quiet_fwd();
        set_id(1, 5'd1, 5'd0, 5'd0, 0, lw_ctrl, 32'h0, 32'h0);
        step();
        set_id(1, 5'd0, 5'd0, 5'd4, 1, add_ctrl, 32'h0, 32'h0);
        #1 check_eq("lw_r0_nostall", 64'(stall_o), 64'd0);
        step();

        // Flush masks the stall and inserts a bubble without counting
        set_id(1, 5'd2, 5'd9, 5'd9, 0, lw_ctrl, 32'h0, 32'h0);
        step();
        sv_cnt = stall_cnt;
        set_id(1, 5'd9, 5'd1, 5'd3, 1, add_ctrl, 32'h0, 32'h0);
        flush = 1;
        #1 check_eq("flush_mask", 64'(stall_o), 64'd0);
        step();
        flush = 0;
        check_eq("flush_valid", 64'(ex_valid), 64'd0);
        check_eq("flush_cnt",   64'(stall_cnt), 64'(sv_cnt));

        // Hold freezes for three cycles
        set_id(1, 5'd2, 5'd3, 5'd4, 1, add_ctrl, 32'hCAFE, 32'hBEEF);
        step();
        sv_valid = ex_valid; sv_ctrl = ex_ctrl; sv_opA = ex_opA; sv_imm = ex_imm; sv_rs = ex_rs;
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            step();
            check_eq("hold_valid", 64'(ex_valid), 64'(sv_valid));
            check_eq("hold_ctrl",  64'(ex_ctrl),  64'(sv_ctrl));
            check_eq("hold_opA",   64'(ex_opA),   64'(sv_opA));
            check_eq("hold_imm",   64'(ex_imm),   64'(sv_imm));
            check_eq("hold_rs",    64'(ex_rs),    64'(sv_rs));
        end
        hold = 0;

        // Saturation: a self-dependent load stalls every other cycle
        set_id(1, 5'd7, 5'd7, 5'd7, 1, lw_ctrl, 32'h0, 32'h0);
        for (int g = 0; g < 2000 && m_cnt < MAXC; g++) step();
        check_eq("sat_reach", 64'(stall_cnt), 64'(MAXC));
        if (!m_valid) step();
        #1 check_eq("sat_stall", 64'(stall_o), 64'd1);
        step();
        check_eq("sat_hold", 64'(stall_cnt), 64'(MAXC));
        step();
        Resetn = 0;
        #1 check_eq("rst_mid_stall", 64'(stall_o), 64'd0);
        step();
        check_eq("rst2_valid", 64'(ex_valid), 64'd0);
        check_eq("rst2_ctrl",  64'(ex_ctrl),  64'd0);
        check_eq("rst2_cnt",   64'(stall_cnt), 64'd0);
        check_eq("rst2_rt",    64'(ex_rt),    64'd0);

        // Random traffic
        Resetn = 1;
        for (int i = 0; i < 2000; i++) begin
            rand_id(); rand_fwd();
            flush  = ($urandom_range(0, 7) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            Resetn = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
